// File: rtl/calc_input_sequencer_pkg.sv
// calc_seq_pkg: FSM state encodings, operation codes and sizing helper for calc_input_sequencer.
package calc_seq_pkg;

    typedef logic [3:0] state_t;

    localparam logic [3:0] WAIT_A    = 4'd0;
    localparam logic [3:0] SETUP_A   = 4'd1;
    localparam logic [3:0] PULSE_A   = 4'd2;
    localparam logic [3:0] WAIT_B    = 4'd3;
    localparam logic [3:0] SETUP_B   = 4'd4;
    localparam logic [3:0] PULSE_B   = 4'd5;
    localparam logic [3:0] SETTLE    = 4'd6;
    localparam logic [3:0] PULSE_OUT = 4'd7;
    localparam logic [3:0] SHOW      = 4'd8;
    localparam logic [3:0] CLEARING  = 4'd9;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/calc_input_sequencer_if.sv
// Key/switch inputs and chain-facing operand/strobe outputs of calc_input_sequencer.
interface calc_input_sequencer_if;
    import calc_seq_pkg::*;

    logic       KEY_ENTER;
    logic       KEY_CLEAR;
    logic [7:0] SW_DATA;
    logic       SW_OP;
    logic [7:0] X;
    logic [7:0] Y;
    logic       InA;
    logic       InB;
    logic       Out;
    logic       Clear;
    logic       Add_Subtract;
    state_t     STATE;
    logic       BUSY;

    modport master (
        input  KEY_ENTER, KEY_CLEAR, SW_DATA, SW_OP,
        output X, Y, InA, InB, Out, Clear, Add_Subtract, STATE, BUSY
    );

    modport slave (
        output KEY_ENTER, KEY_CLEAR, SW_DATA, SW_OP,
        input  X, Y, InA, InB, Out, Clear, Add_Subtract, STATE, BUSY
    );

endinterface

// File: rtl/calc_input_sequencer_key_conditioner.sv
// key_conditioner: synchroniser chain, optional debounce (CALC_SEQ_DEBOUNCE_EN), rising-edge event.
module key_conditioner #(
    parameter int unsigned SYNC_STAGES = 2
`ifdef CALC_SEQ_DEBOUNCE_EN
    ,
    parameter int unsigned DEB_CYC = 16
`endif
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key,
    output logic o_event
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    logic                   w_level;
    logic                   r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_key};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef CALC_SEQ_DEBOUNCE_EN
    localparam int unsigned DW = $clog2(DEB_CYC) + 1;

    logic          r_filt;
    logic [DW-1:0] r_deb_cnt;

    // Any return to the filtered level restarts the stability count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_filt    <= 1'b0;
            r_deb_cnt <= '0;
        end else if (w_sync == r_filt) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt == DW'(DEB_CYC - 1)) begin
            r_filt    <= w_sync;
            r_deb_cnt <= '0;
        end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = w_sync;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_level;
        end
    end

    assign o_event = w_level & ~r_prev;

endmodule

// File: rtl/calc_input_sequencer.sv
// calc_input_sequencer: turns ENTER/CLEAR keys and switches into operand buses and load strobes
// for the add/subtract chain. Define CALC_SEQ_DEBOUNCE_EN to debounce the keys.
module calc_input_sequencer
    import calc_seq_pkg::*;
#(
    parameter int unsigned PULSE_W     = 2,
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYC     = 16
) (
    input logic                   CLK,
    input logic                   CLR,
    calc_input_sequencer_if.master bus
);

    localparam int unsigned CW = $clog2(max3(PULSE_W, SETTLE_CYC, DEB_CYC)) + 1;

    logic          w_enter_ev;
    logic          w_clear_ev;
    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_load;
    logic          w_entry;
    logic          w_cnt_done;

    logic [7:0]    r_x;
    logic [7:0]    r_y;
    logic          r_as;
    logic          r_ina;
    logic          r_inb;
    logic          r_out;
    logic          r_clear;
    logic          r_busy;

`ifdef CALC_SEQ_DEBOUNCE_EN
    key_conditioner #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYC(DEB_CYC)) u_enter (
        .i_clk(CLK), .i_rst(CLR), .i_key(bus.KEY_ENTER), .o_event(w_enter_ev)
    );
    key_conditioner #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYC(DEB_CYC)) u_clear (
        .i_clk(CLK), .i_rst(CLR), .i_key(bus.KEY_CLEAR), .o_event(w_clear_ev)
    );
`else
    key_conditioner #(.SYNC_STAGES(SYNC_STAGES)) u_enter (
        .i_clk(CLK), .i_rst(CLR), .i_key(bus.KEY_ENTER), .o_event(w_enter_ev)
    );
    key_conditioner #(.SYNC_STAGES(SYNC_STAGES)) u_clear (
        .i_clk(CLK), .i_rst(CLR), .i_key(bus.KEY_CLEAR), .o_event(w_clear_ev)
    );
`endif

    assign w_cnt_done = (r_cnt == '0);

    // Clear overrides everything, so enter in the same cycle is discarded.
    always_comb begin
        w_next = r_state;
        if (w_clear_ev) begin
            w_next = CLEARING;
        end else begin
            case (r_state)
                WAIT_A:    if (w_enter_ev) w_next = SETUP_A;
                SETUP_A:   w_next = PULSE_A;
                PULSE_A:   if (w_cnt_done) w_next = WAIT_B;
                WAIT_B:    if (w_enter_ev) w_next = SETUP_B;
                SETUP_B:   w_next = PULSE_B;
                PULSE_B:   if (w_cnt_done) w_next = SETTLE;
                SETTLE:    if (w_cnt_done) w_next = PULSE_OUT;
                PULSE_OUT: if (w_cnt_done) w_next = SHOW;
                SHOW:      if (w_enter_ev) w_next = SETUP_A;
                CLEARING:  if (w_cnt_done) w_next = WAIT_A;
                default:   w_next = WAIT_A;
            endcase
        end
    end

    always_comb begin
        w_load = '0;
        case (w_next)
            PULSE_A, PULSE_B, PULSE_OUT, CLEARING: w_load = CW'(PULSE_W - 1);
            SETTLE:                                w_load = CW'(SETTLE_CYC - 1);
            default:                               w_load = '0;
        endcase
    end

    // A repeated clear counts as a fresh entry into CLEARING.
    assign w_entry = (w_next != r_state) | w_clear_ev;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_state <= WAIT_A;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_entry) begin
                r_cnt <= w_load;
            end else if (!w_cnt_done) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Outputs are decoded from the next state so they line up with r_state yet stay registered.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_x     <= '0;
            r_y     <= '0;
            r_as    <= OP_ADD;
            r_ina   <= 1'b0;
            r_inb   <= 1'b0;
            r_out   <= 1'b0;
            r_clear <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            if (w_next == CLEARING) begin
                r_x  <= '0;
                r_y  <= '0;
                r_as <= OP_ADD;
            end else begin
                if (w_next == SETUP_A) begin
                    r_x <= bus.SW_DATA;
                end
                if (w_next == SETUP_B) begin
                    r_y  <= bus.SW_DATA;
                    r_as <= bus.SW_OP;
                end
            end
            r_ina   <= (w_next == PULSE_A);
            r_inb   <= (w_next == PULSE_B);
            r_out   <= (w_next == PULSE_OUT);
            r_clear <= (w_next == CLEARING);
            r_busy  <= !((w_next == WAIT_A) || (w_next == WAIT_B) || (w_next == SHOW));
        end
    end

    assign bus.X            = r_x;
    assign bus.Y            = r_y;
    assign bus.Add_Subtract = r_as;
    assign bus.InA          = r_ina;
    assign bus.InB          = r_inb;
    assign bus.Out          = r_out;
    assign bus.Clear        = r_clear;
    assign bus.STATE        = r_state;
    assign bus.BUSY         = r_busy;

endmodule

// File: tb/tb_calc_input_sequencer.sv
// Self-checking bench for calc_input_sequencer: vector table for full add/subtract flows plus
// directed key-hold, busy-press, clear and bounce sequences.
module tb_calc_input_sequencer;
    import calc_seq_pkg::*;

    localparam int PW   = 2;
    localparam int SC   = 4;
    localparam int SYNC = 2;
    localparam int DEB  = 16;
`ifdef CALC_SEQ_DEBOUNCE_EN
    localparam int KEY_LAT = SYNC + DEB;
`else
    localparam int KEY_LAT = SYNC;
`endif

    logic clk = 1'b0;
    logic rst;

    calc_input_sequencer_if bus();

    calc_input_sequencer #(
        .PULSE_W(PW), .SETTLE_CYC(SC), .SYNC_STAGES(SYNC), .DEB_CYC(DEB)
    ) dut (
        .CLK(clk), .CLR(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        e;
        logic [7:0]  d;
        logic        op;
        logic [29:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] res_log[$];
    int n_checks = 0;
    int n_pass   = 0;
    int e_ina = 0, e_inb = 0, e_out = 0, e_clr = 0;
    int viol  = 0;
    int s_a, s_b, s_o, s_c;

    logic [3:0] m_st;
    logic [7:0] m_x, m_y;
    logic       m_as;

    // Edge counters, chain result model and output invariants.
    logic        p_ina, p_inb, p_out, p_clr;
    logic [16:0] p_dat;
    always @(negedge clk) begin
        if (rst) begin
            p_ina = 1'b0; p_inb = 1'b0; p_out = 1'b0; p_clr = 1'b0;
            p_dat = '0;
        end else begin
            if (bus.InA && !p_ina) e_ina++;
            if (bus.InB && !p_inb) e_inb++;
            if (bus.Clear && !p_clr) e_clr++;
            if (bus.Out && !p_out) begin
                e_out++;
                res_log.push_back(bus.Add_Subtract ? bus.X - bus.Y : bus.X + bus.Y);
            end
            if (32'(bus.InA) + 32'(bus.InB) + 32'(bus.Out) + 32'(bus.Clear) > 1) viol++;
            if (bus.STATE != CLEARING &&
                (bus.InA || bus.InB || bus.Out || bus.STATE == SETTLE || bus.STATE == PULSE_OUT) &&
                {bus.X, bus.Y, bus.Add_Subtract} != p_dat) viol++;
            p_ina = bus.InA; p_inb = bus.InB; p_out = bus.Out; p_clr = bus.Clear;
            p_dat = {bus.X, bus.Y, bus.Add_Subtract};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic snap();
        s_a = e_ina; s_b = e_inb; s_o = e_out; s_c = e_clr;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [29:0] pack(input logic [3:0] st, input logic [7:0] x,
                                         input logic [7:0] y, input logic ina, input logic inb,
                                         input logic out, input logic clr, input logic as_,
                                         input logic busy);
        return {st, x, y, ina, inb, out, clr, as_, busy};
    endfunction

    function automatic logic [29:0] dut_out();
        return {bus.STATE, bus.X, bus.Y, bus.InA, bus.InB, bus.Out, bus.Clear,
                bus.Add_Subtract, bus.BUSY};
    endfunction

    task automatic push(input logic e, input logic [7:0] d, input logic op, input logic [3:0] st,
                        input logic ina, input logic inb, input logic out);
        vec_t v;
        logic busy;
        busy  = !(st == WAIT_A || st == WAIT_B || st == SHOW);
        v.e   = e;
        v.d   = d;
        v.op  = op;
        v.exp = pack(st, m_x, m_y, ina, inb, out, 1'b0, m_as, busy);
        vecs.push_back(v);
    endtask

    // One complete operation: A press, InA pulse, B press, InB pulse, settle, Out pulse.
    task automatic add_flow(input logic [7:0] a, input logic [7:0] b, input logic op);
        for (int i = 0; i < KEY_LAT; i++) push(1'b1, a, 1'b0, m_st, 1'b0, 1'b0, 1'b0);
        m_x = a;
        push(1'b0, a, 1'b0, SETUP_A, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < PW; i++) push(1'b0, a, 1'b0, PULSE_A, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i <= KEY_LAT; i++) push(1'b0, b, op, WAIT_B, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < KEY_LAT; i++) push(1'b1, b, op, WAIT_B, 1'b0, 1'b0, 1'b0);
        m_y  = b;
        m_as = op;
        push(1'b0, b, op, SETUP_B, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < PW; i++) push(1'b0, b, op, PULSE_B, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < SC; i++) push(1'b0, b, op, SETTLE, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < PW; i++) push(1'b0, b, op, PULSE_OUT, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i <= KEY_LAT; i++) push(1'b0, b, op, SHOW, 1'b0, 1'b0, 1'b0);
        m_st = SHOW;
    endtask

    task automatic wait_state(input logic [3:0] st, input string name);
        int n;
        n = 0;
        while (bus.STATE !== st && n < 200) begin
            tick();
            n++;
        end
        check(name, 32'(bus.STATE), 32'(st));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r0, r1;
        int first_ina;

        rst = 1'b1;
        bus.KEY_ENTER = 1'b0;
        bus.KEY_CLEAR = 1'b0;
        bus.SW_DATA   = 8'h00;
        bus.SW_OP     = OP_ADD;

        // Reset and quiet period.
        idle(3);
        check("reset_active", {2'b00, dut_out()}, {2'b00, pack(WAIT_A, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0)});
        rst = 1'b0;
        tick();
        check("reset_release", {2'b00, dut_out()}, {2'b00, pack(WAIT_A, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0)});
        snap();
        idle(100);
        check("idle_edges", 32'((e_ina - s_a) + (e_inb - s_b) + (e_out - s_o) + (e_clr - s_c)), 32'd0);
        check("idle_state", {2'b00, dut_out()}, {2'b00, pack(WAIT_A, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0)});

        // Vector table: add 0x25+0x13 then subtract 0x10-0x30 from SHOW.
        m_st = WAIT_A; m_x = 8'h00; m_y = 8'h00; m_as = OP_ADD;
        add_flow(8'h25, 8'h13, OP_ADD);
        add_flow(8'h10, 8'h30, OP_SUB);
        foreach (vecs[i]) begin
            bus.KEY_ENTER = vecs[i].e;
            bus.SW_DATA   = vecs[i].d;
            bus.SW_OP     = vecs[i].op;
            tick();
            check($sformatf("vec%0d", i), {2'b00, dut_out()}, {2'b00, vecs[i].exp});
        end
        check("result_count", 32'(res_log.size()), 32'd2);
        r0 = (res_log.size() > 0) ? res_log[0] : 8'hxx;
        r1 = (res_log.size() > 1) ? res_log[1] : 8'hxx;
        check("result_add", 32'(r0), 32'h38);
        check("result_sub", 32'(r1), 32'hE0);

        // ENTER held 50 cycles from SHOW: exactly one A operation.
        snap();
        bus.SW_DATA = 8'h5A;
        bus.KEY_ENTER = 1'b1;
        idle(50);
        bus.KEY_ENTER = 1'b0;
        idle(KEY_LAT + 2);
        check("hold_ina_edges", 32'(e_ina - s_a), 32'd1);
        check("hold_state", 32'(bus.STATE), 32'(WAIT_B));
        check("hold_x", 32'(bus.X), 32'h5A);

        // Second press lands in SETTLE and must be dropped.
        snap();
        bus.SW_DATA = 8'h21;
        bus.KEY_ENTER = 1'b1; idle(KEY_LAT);
        bus.KEY_ENTER = 1'b0; idle(2);
        bus.KEY_ENTER = 1'b1; idle(2);
        bus.KEY_ENTER = 1'b0;
        idle(20 + KEY_LAT);
        check("busy_state", 32'(bus.STATE), 32'(SHOW));
        check("busy_inb_edges", 32'(e_inb - s_b), 32'd1);
        check("busy_out_edges", 32'(e_out - s_o), 32'd1);
        check("busy_ina_edges", 32'(e_ina - s_a), 32'd0);

        // CLEAR during PULSE_A.
        snap();
        bus.SW_DATA = 8'h55;
        for (int t = 1; t <= KEY_LAT + PW + 4; t++) begin
            bus.KEY_ENTER = (t <= KEY_LAT);
            bus.KEY_CLEAR = (t >= 3 && t <= KEY_LAT + 2);
            tick();
            if (t == KEY_LAT + 2) begin
                check("clr_pre_state", 32'(bus.STATE), 32'(PULSE_A));
                check("clr_pre_ina", 32'(bus.InA), 32'd1);
                check("clr_pre_x", 32'(bus.X), 32'h55);
            end
            if (t == KEY_LAT + 3) begin
                check("clr_state", 32'(bus.STATE), 32'(CLEARING));
                check("clr_ina_drop", 32'(bus.InA), 32'd0);
                check("clr_strobe", 32'(bus.Clear), 32'd1);
                check("clr_data", 32'({bus.X, bus.Y, bus.Add_Subtract}), 32'd0);
            end
            if (t == KEY_LAT + 2 + PW) check("clr_last", 32'(bus.Clear), 32'd1);
            if (t == KEY_LAT + 3 + PW) begin
                check("clr_done_state", 32'(bus.STATE), 32'(WAIT_A));
                check("clr_done_strobe", 32'(bus.Clear), 32'd0);
            end
        end
        check("clr_edges", 32'(e_clr - s_c), 32'd1);
        idle(KEY_LAT + 2);

        // Simultaneous CLEAR and ENTER in WAIT_B.
        bus.SW_DATA = 8'h3C;
        bus.KEY_ENTER = 1'b1; idle(KEY_LAT);
        bus.KEY_ENTER = 1'b0;
        wait_state(WAIT_B, "reach_wait_b");
        idle(KEY_LAT + 2);
        check("both_pre_x", 32'(bus.X), 32'h3C);
        snap();
        bus.SW_DATA = 8'h77;
        bus.SW_OP   = OP_SUB;
        bus.KEY_ENTER = 1'b1;
        bus.KEY_CLEAR = 1'b1;
        idle(KEY_LAT);
        bus.KEY_ENTER = 1'b0;
        bus.KEY_CLEAR = 1'b0;
        tick();
        check("both_state", 32'(bus.STATE), 32'(CLEARING));
        check("both_strobes", 32'({bus.InB, bus.Clear}), 32'b01);
        check("both_data", 32'({bus.X, bus.Y, bus.Add_Subtract}), 32'd0);
        idle(PW);
        check("both_done", {2'b00, dut_out()}, {2'b00, pack(WAIT_A, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0)});
        idle(10 + KEY_LAT);
        check("both_inb_edges", 32'(e_inb - s_b), 32'd0);
        check("both_ina_edges", 32'(e_ina - s_a), 32'd0);
        check("both_clr_edges", 32'(e_clr - s_c), 32'd1);

        // Bouncing ENTER: five 3-cycle bounces then stable.
        rst = 1'b1; idle(2); rst = 1'b0; idle(5);
        snap();
        bus.SW_DATA = 8'h0F;
        bus.SW_OP   = OP_ADD;
        for (int i = 0; i < 5; i++) begin
            bus.KEY_ENTER = 1'b1; idle(3);
            bus.KEY_ENTER = 1'b0; idle(3);
        end
        first_ina = -1;
        bus.KEY_ENTER = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (bus.InA && first_ina < 0) first_ina = t;
        end
        bus.KEY_ENTER = 1'b0;
        idle(40 + KEY_LAT);
`ifdef CALC_SEQ_DEBOUNCE_EN
        check("deb_latency", 32'(first_ina), 32'(KEY_LAT + 2));
        check("deb_ina_edges", 32'(e_ina - s_a), 32'd1);
        check("deb_inb_edges", 32'(e_inb - s_b), 32'd0);
        check("deb_state", 32'(bus.STATE), 32'(WAIT_B));
`else
        check("bounce_ina_edges", 32'(e_ina - s_a), 32'd2);
        check("bounce_inb_edges", 32'(e_inb - s_b), 32'd2);
        check("bounce_out_edges", 32'(e_out - s_o), 32'd2);
        check("bounce_state", 32'(bus.STATE), 32'(SHOW));
`endif

        check("invariants", 32'(viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
